// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/funct constants, extender encoding and control bundle
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Extender encoding: the immediate extender decodes exactly these values.
  typedef enum logic [1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_LUI   = 2'b10,
    EXT_SHAMT = 2'b11
  } ext_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
  } ctrl_t;

  function automatic logic funct_legal(input logic [5:0] funct);
    case (funct)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      FN_SLT, FN_SLTU: funct_legal = 1'b1;
      default:         funct_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/if_id_decode_if.sv
// rtl/if_id_decode_if.sv - fetch-side handshake and decoded ID-side bundle
interface if_id_decode_if;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [1:0]  ext_op;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        alu_src;
  logic        reg_dst;
  logic        illegal;

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  if_ready, id_valid, id_pc, id_instr, rs, rt, rd, imm16, ext_op,
           reg_write, mem_read, mem_write, alu_src, reg_dst, illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output if_ready, id_valid, id_pc, id_instr, rs, rt, rd, imm16, ext_op,
           reg_write, mem_read, mem_write, alu_src, reg_dst, illegal
  );

endinterface

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational main decoder: opcode/funct to extender mode, control, illegal
module id_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ext_op_e    ext_op_o,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  ext_op_e ext_d;
  ctrl_t   ctrl_d;
  logic    illegal_d;

  always_comb begin
    ext_d     = EXT_ZERO;
    ctrl_d    = '0;
    illegal_d = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
        if (funct_i == FN_SLL || funct_i == FN_SRL || funct_i == FN_SRA) ext_d = EXT_SHAMT;
        illegal_d = !funct_legal(funct_i);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ext_d            = EXT_SIGN;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_LW: begin
        ext_d            = EXT_SIGN;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_SW: begin
        ext_d            = EXT_SIGN;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_BEQ, OP_BNE: ext_d = EXT_SIGN;
      OP_LUI: begin
        ext_d            = EXT_LUI;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
      end
      OP_J:    ;
      OP_JAL:  ctrl_d.reg_write = 1'b1;
      default: illegal_d = 1'b1;
    endcase
    // An unrecognised instruction must not cause any architectural effect.
    if (illegal_d) begin
      ext_d  = EXT_ZERO;
      ctrl_d = '0;
    end
  end

  assign ext_op_o  = ext_d;
  assign ctrl_o    = ctrl_d;
  assign illegal_o = illegal_d;

endmodule

// File: rtl/if_id_decode.sv
// rtl/if_id_decode.sv - IF/ID pipeline register holding the instruction and its registered decode
module if_id_decode
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  if_id_decode_if.slave bus
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, instr_q;
  ext_op_e     ext_q, ext_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic        illegal_q, illegal_d;
  logic        load;

  id_decoder u_dec (
    .op_i      (bus.if_instr[31:26]),
    .funct_i   (bus.if_instr[5:0]),
    .ext_op_o  (ext_d),
    .ctrl_o    (ctrl_d),
    .illegal_o (illegal_d)
  );

  assign load    = !valid_q || bus.ex_ready;
  assign valid_d = bus.flush ? 1'b0 : (load ? bus.if_valid : valid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      instr_q   <= '0;
      ext_q     <= EXT_ZERO;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      // A flushed beat is dropped entirely; the held payload stays put.
      if (load && !bus.flush) begin
        pc_q      <= bus.if_pc;
        instr_q   <= bus.if_instr;
        ext_q     <= ext_d;
        ctrl_q    <= ctrl_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign bus.if_ready  = load;
  assign bus.id_valid  = valid_q;
  assign bus.id_pc     = pc_q;
  assign bus.id_instr  = instr_q;
  assign bus.rs        = instr_q[25:21];
  assign bus.rt        = instr_q[20:16];
  assign bus.rd        = instr_q[15:11];
  assign bus.imm16     = instr_q[15:0];
  assign bus.ext_op    = ext_q;
  // Bubbles must not write registers or memory.
  assign bus.reg_write = ctrl_q.reg_write & valid_q;
  assign bus.mem_read  = ctrl_q.mem_read  & valid_q;
  assign bus.mem_write = ctrl_q.mem_write & valid_q;
  assign bus.alu_src   = ctrl_q.alu_src;
  assign bus.reg_dst   = ctrl_q.reg_dst;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_if_id_decode.sv
// tb/tb_if_id_decode.sv - directed self-checking bench for if_id_decode
module tb_if_id_decode;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  if_id_decode_if bus ();

  if_id_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.flush    = 1'b0;
    bus.ex_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    chk("rst_id_valid", bus.id_valid, 0);
    chk("rst_id_pc",    bus.id_pc, 0);
    chk("rst_id_instr", bus.id_instr, 0);
    chk("rst_ext_op",   bus.ext_op, 0);
    chk("rst_illegal",  bus.illegal, 0);
    chk("rst_alu_src",  bus.alu_src, 0);
    chk("rst_if_ready", bus.if_ready, 1);
    rst_n = 1'b1;
    step();

    drive(1'b1, 32'h342100FF, 32'h100);
    step();
    chk("ori_valid", bus.id_valid, 1);
    chk("ori_rs",    bus.rs, 1);
    chk("ori_rt",    bus.rt, 1);
    chk("ori_imm",   bus.imm16, 16'h00FF);
    chk("ori_ext",   bus.ext_op, 2'b00);
    chk("ori_alusrc", bus.alu_src, 1);
    chk("ori_rw",    bus.reg_write, 1);
    chk("ori_pc",    bus.id_pc, 32'h100);

    drive(1'b1, 32'h3C011234, 32'h104);
    step();
    chk("lui_ext", bus.ext_op, 2'b10);
    chk("lui_imm", bus.imm16, 16'h1234);
    chk("lui_rt",  bus.rt, 1);
    chk("lui_rw",  bus.reg_write, 1);

    drive(1'b1, 32'h8C22FFFC, 32'h108);
    step();
    chk("lw_ext", bus.ext_op, 2'b01);
    chk("lw_mr",  bus.mem_read, 1);
    chk("lw_mw",  bus.mem_write, 0);
    chk("lw_rs",  bus.rs, 1);
    chk("lw_rt",  bus.rt, 2);

    drive(1'b1, 32'h00011080, 32'h10C);
    step();
    chk("sll_ext",    bus.ext_op, 2'b11);
    chk("sll_rd",     bus.rd, 2);
    chk("sll_regdst", bus.reg_dst, 1);
    chk("sll_shamt",  {27'd0, bus.imm16[10:6]}, 2);
    chk("sll_alusrc", bus.alu_src, 0);
    chk("sll_ill",    bus.illegal, 0);

    drive(1'b1, 32'h20220005, 32'h110);
    step();
    bus.ex_ready = 1'b0;
    drive(1'b1, 32'hAC220004, 32'h114);
    #1;
    chk("stall_ready0", bus.if_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", bus.if_ready, 0);
      chk("stall_valid", bus.id_valid, 1);
      chk("stall_instr", bus.id_instr, 32'h20220005);
      chk("stall_pc",    bus.id_pc, 32'h110);
      chk("stall_ext",   bus.ext_op, 2'b01);
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("unstall_ready", bus.if_ready, 1);
    step();
    chk("sw_instr", bus.id_instr, 32'hAC220004);
    chk("sw_mw",    bus.mem_write, 1);
    chk("sw_rw",    bus.reg_write, 0);
    chk("sw_alusrc", bus.alu_src, 1);

    bus.ex_ready = 1'b0;
    bus.flush    = 1'b1;
    drive(1'b1, 32'h342100FF, 32'h200);
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_valid", bus.id_valid, 0);
    chk("flush_rw",    bus.reg_write, 0);
    chk("flush_mw_gated", bus.mem_write, 0);
    chk("flush_instr", bus.id_instr, 32'hAC220004);
    #1;
    chk("flush_ready", bus.if_ready, 1);

    bus.ex_ready = 1'b1;
    drive(1'b1, 32'hFC000000, 32'h300);
    step();
    chk("ill_valid", bus.id_valid, 1);
    chk("ill_flag",  bus.illegal, 1);
    chk("ill_ctrl",  {27'd0, bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_src, bus.reg_dst}, 0);

    drive(1'b1, 32'h00000001, 32'h304);
    step();
    chk("ill_funct", bus.illegal, 1);
    chk("ill_funct_regdst", bus.reg_dst, 0);
    chk("ill_funct_rw", bus.reg_write, 0);

    drive(1'b0, 32'h8C22FFFC, 32'h308);
    step();
    chk("bubble_valid", bus.id_valid, 0);
    chk("bubble_mr",    bus.mem_read, 0);
    chk("bubble_instr", bus.id_instr, 32'h8C22FFFC);
    chk("bubble_alusrc", bus.alu_src, 1);

    drive(1'b1, 32'h20220005, 32'h400);
    step();
    bus.ex_ready = 1'b0;
    drive(1'b1, 32'h3C011234, 32'h404);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.id_valid, 0);
    chk("arst_pc",    bus.id_pc, 0);
    chk("arst_instr", bus.id_instr, 0);
    chk("arst_rs",    bus.rs, 0);
    chk("arst_imm",   bus.imm16, 0);
    chk("arst_ext",   bus.ext_op, 0);
    chk("arst_alusrc", bus.alu_src, 0);
    chk("arst_rw",    bus.reg_write, 0);
    chk("arst_ready", bus.if_ready, 1);
    step();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("post_rst_valid", bus.id_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
